// File: rtl/iq_mixer_mc_pkg.sv
// Shared widths, quadrant codes, LFSR constants and LUT helper
// for the multi-channel IQ mixer.
package iq_mixer_mc_pkg;

   localparam logic [1:0] QUAD0 = 2'd0;
   localparam logic [1:0] QUAD1 = 2'd1;
   localparam logic [1:0] QUAD2 = 2'd2;
   localparam logic [1:0] QUAD3 = 2'd3;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // bits 0,2,3,5 of a right-shifting register: x^16+x^14+x^13+x^11+1
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

   localparam longint PI_Q60 = 64'h3243_F6A8_885A_308D;

   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int rnd_shift(input int in_w, input int out_w,
                                    input int amp_w);
      return amp_w - 1 - (out_w - in_w);
   endfunction

   // round(peak*sin(pi*(2k+1)/2^lut_aw)), fixed-point Taylor series
   function automatic int lut_val(input int k, input int amp_w,
                                  input int lut_aw);
      longint x, x2, term, sum, peak;
      x    = ((PI_Q60 >>> 30) * longint'(2 * k + 1)) >>> lut_aw;
      x2   = (x * x) >>> 30;
      term = x;
      sum  = x;
      for (int n = 1; n <= 9; n++) begin
         term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
         sum  = sum + term;
      end
      peak = (longint'(1) <<< (amp_w - 1)) - 1;
      return int'((peak * sum + (longint'(1) <<< 29)) >>> 30);
   endfunction

endpackage

// File: rtl/nco_sincos_lut.sv
// Quarter-wave sin/cos ROM with quadrant folding; two register
// stages from phase to folded sin/cos.
module nco_sincos_lut
   import iq_mixer_mc_pkg::*;
#(
   parameter int AMP_W  = 18,
   parameter int LUT_AW = 12
) (
   input  logic                    clk,
   input  logic [LUT_AW-1:0]       phase,
   output logic signed [AMP_W-1:0] sin_val,
   output logic signed [AMP_W-1:0] cos_val
);

   localparam int IW = LUT_AW - 2;
   localparam int QN = 1 << IW;

   logic [AMP_W-1:0] rom [QN];

   for (genvar k = 0; k < QN; k++) begin : g_rom
      localparam logic [AMP_W-1:0] V = AMP_W'(lut_val(k, AMP_W, LUT_AW));
      assign rom[k] = V;
   end

   logic [1:0]    quad;
   logic [IW-1:0] idx;

   always_ff @(posedge clk) begin
      quad <= phase[LUT_AW-1 -: 2];
      idx  <= phase[IW-1:0];
   end

   logic signed [AMP_W-1:0] s_raw;
   logic signed [AMP_W-1:0] c_raw;

   // ~idx == Q-1-idx: the half-bin offset makes this mirror exact
   always_comb begin
      s_raw = rom[idx];
      c_raw = rom[~idx];
   end

   always_ff @(posedge clk) begin
      unique case (quad)
         QUAD0: begin
            cos_val <= c_raw;
            sin_val <= s_raw;
         end
         QUAD1: begin
            cos_val <= -s_raw;
            sin_val <= c_raw;
         end
         QUAD2: begin
            cos_val <= -c_raw;
            sin_val <= -s_raw;
         end
         QUAD3: begin
            cos_val <= s_raw;
            sin_val <= -c_raw;
         end
      endcase
   end

endmodule

// File: rtl/iq_mixer_mc.sv
// Time-multiplexed NCH-channel IQ mixer, fixed 5-cycle latency.
// Optional phase dither: define IQ_MIXER_MC_DITHER_EN.
module iq_mixer_mc
   import iq_mixer_mc_pkg::*;
#(
   parameter  int NCH     = 4,
   parameter  int IN_W    = 14,
   parameter  int OUT_W   = 24,
   parameter  int AMP_W   = 18,
   parameter  int PHASE_W = 32,
   parameter  int LUT_AW  = 12,
   localparam int CH_W    = ch_w(NCH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic [CH_W-1:0]         in_chan,
   input  logic signed [IN_W-1:0]  in_data,
   input  logic                    cfg_we,
   input  logic                    cfg_zero,
   input  logic [CH_W-1:0]         cfg_chan,
   input  logic [PHASE_W-1:0]      cfg_pinc,
   output logic                    out_valid,
   output logic [CH_W-1:0]         out_chan,
   output logic signed [OUT_W-1:0] out_i,
   output logic signed [OUT_W-1:0] out_q
);

   localparam int SH = rnd_shift(IN_W, OUT_W, AMP_W);
   localparam int PW = IN_W + AMP_W;
   localparam int RW = (PW > OUT_W) ? PW + 1 : OUT_W + 1;

   localparam logic signed [RW-1:0] RND  = RW'(64'd1 << (SH - 1));
   localparam logic signed [RW-1:0] MAXV =
      RW'({1'b0, {(OUT_W-1){1'b1}}});
   localparam logic signed [RW-1:0] MINV = ~MAXV;

   logic [PHASE_W-1:0] acc  [NCH];
   logic [PHASE_W-1:0] pinc [NCH];

   logic chan_ok;
   logic take;

   if ((1 << CH_W) == NCH) begin : g_full
      assign chan_ok = 1'b1;
   end else begin : g_part
      assign chan_ok = (in_chan < CH_W'(NCH));
   end

   assign take = in_valid & chan_ok;

   logic [PHASE_W-1:0] lut_phase;

`ifdef IQ_MIXER_MC_DITHER_EN
   localparam int DW = PHASE_W - LUT_AW;

   logic [15:0]        lfsr;
   logic [PHASE_W-1:0] dith;

   always_comb begin
      dith = '0;
      for (int b = 0; b < DW && b < 16; b++) dith[b] = lfsr[b];
   end

   always_ff @(posedge clk) begin
      if (rst) lfsr <= LFSR_SEED;
      else if (take) lfsr <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
   end

   // dither touches the LUT address only, never the stored phase
   assign lut_phase = acc[in_chan] + dith;
`else
   assign lut_phase = acc[in_chan];
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < NCH; c++) begin
            acc[c]  <= '0;
            pinc[c] <= '0;
         end
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (cfg_zero && cfg_chan == CH_W'(c))
               acc[c] <= '0;
            else if (take && in_chan == CH_W'(c))
               acc[c] <= acc[c] + pinc[c];
            if (cfg_we && cfg_chan == CH_W'(c))
               pinc[c] <= cfg_pinc;
         end
      end
   end

   logic                    s1_v, s2_v, s3_v, s4_v;
   logic [CH_W-1:0]         s1_ch, s2_ch, s3_ch, s4_ch;
   logic signed [IN_W-1:0]  s1_data, s2_data, s3_data;
   logic [LUT_AW-1:0]       s1_addr;
   logic signed [AMP_W-1:0] lut_sin, lut_cos;
   logic signed [PW-1:0]    s4_pi, s4_pq;

   always_ff @(posedge clk) begin
      s1_data <= in_data;
      s1_addr <= LUT_AW'(lut_phase >> (PHASE_W - LUT_AW));
      s2_data <= s1_data;
      s3_data <= s2_data;
      s4_pi   <= s3_data * lut_cos;
      s4_pq   <= s3_data * lut_sin;
   end

   nco_sincos_lut #(
      .AMP_W  (AMP_W),
      .LUT_AW (LUT_AW)
   ) u_lut (
      .clk     (clk),
      .phase   (s1_addr),
      .sin_val (lut_sin),
      .cos_val (lut_cos)
   );

   function automatic logic signed [OUT_W-1:0] rnd_sat(
      input logic signed [PW-1:0] p
   );
      logic signed [RW-1:0] t;
      t = (RW'(p) + RND) >>> SH;
      if (t > MAXV) return OUT_W'(MAXV);
      if (t < MINV) return OUT_W'(MINV);
      return OUT_W'(t);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v      <= 1'b0;
         s2_v      <= 1'b0;
         s3_v      <= 1'b0;
         s4_v      <= 1'b0;
         out_valid <= 1'b0;
         s1_ch     <= '0;
         s2_ch     <= '0;
         s3_ch     <= '0;
         s4_ch     <= '0;
         out_chan  <= '0;
         out_i     <= '0;
         out_q     <= '0;
      end else begin
         s1_v      <= take;
         s2_v      <= s1_v;
         s3_v      <= s2_v;
         s4_v      <= s3_v;
         out_valid <= s4_v;
         s1_ch     <= in_chan;
         s2_ch     <= s1_ch;
         s3_ch     <= s2_ch;
         s4_ch     <= s3_ch;
         // outputs hold their last result between strobes
         if (s4_v) begin
            out_chan <= s4_ch;
            out_i    <= rnd_sat(s4_pi);
            out_q    <= rnd_sat(s4_pq);
         end
      end
   end

endmodule

// File: tb/tb_iq_mixer_mc.sv
// Scoreboard bench for iq_mixer_mc: directed vectors with
// hand-computed I/Q per quadrant, monitor checks tag and latency.
module tb_iq_mixer_mc;

   localparam int NCH = 4;
   // peak 131071, LUT[0]=101, LUT[1023]=131071, shift 7, round-half-up
   localparam int BIG = 1023992;
   localparam int SML = 789;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic [1:0]         in_chan;
   logic signed [13:0] in_data;
   logic               cfg_we;
   logic               cfg_zero;
   logic [1:0]         cfg_chan;
   logic [31:0]        cfg_pinc;
   logic               out_valid;
   logic [1:0]         out_chan;
   logic signed [23:0] out_i;
   logic signed [23:0] out_q;

   iq_mixer_mc dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_chan   (in_chan),
      .in_data   (in_data),
      .cfg_we    (cfg_we),
      .cfg_zero  (cfg_zero),
      .cfg_chan  (cfg_chan),
      .cfg_pinc  (cfg_pinc),
      .out_valid (out_valid),
      .out_chan  (out_chan),
      .out_i     (out_i),
      .out_q     (out_q)
   );

   always #5 clk = ~clk;

   typedef struct {
      int chan;
      int i;
      int q;
      int cyc;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   lat;
   int   quad [NCH];
   int   step [NCH];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int exp_i(input int d, input int q);
      int b;
      if (d == -8192) return -8388544;
      case (q)
         0:       b = BIG;
         1:       b = -SML;
         2:       b = -BIG;
         default: b = SML;
      endcase
      return (d > 0) ? b : -b;
   endfunction

   function automatic int exp_q(input int d, input int q);
      int b;
      if (d == -8192) return -6464;
      case (q)
         0:       b = SML;
         1:       b = BIG;
         2:       b = -SML;
         default: b = -BIG;
      endcase
      return (d > 0) ? b : -b;
   endfunction

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic cyc1(input logic v, input int c, input int d,
                       input logic we, input logic zero, input int cc,
                       input logic [31:0] pv);
      in_valid = v;
      in_chan  = c[1:0];
      in_data  = d[13:0];
      cfg_we   = we;
      cfg_zero = zero;
      cfg_chan = cc[1:0];
      cfg_pinc = pv;
      if (v) begin
         sb.push_back('{c, exp_i(d, quad[c]), exp_q(d, quad[c]), cyc});
         quad[c] = (quad[c] + step[c]) % 4;
      end
      if (zero) quad[cc] = 0;
      if (we) step[cc] = int'(pv >> 30);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      cfg_we   = 1'b0;
      cfg_zero = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   always @(negedge clk) begin
      if (out_valid) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out chan=%0d i=%0d q=%0d required=none",
                     out_chan, out_i, out_q);
         end else begin
            e   = sb.pop_front();
            lat = cyc - e.cyc;
            if (int'(out_chan) != e.chan || int'(out_i) != e.i ||
                int'(out_q) != e.q || lat != 5) begin
               errors++;
               $display("FAIL out chan=%0d/%0d i=%0d/%0d q=%0d/%0d lat=%0d/5 (actual/required)",
                        out_chan, e.chan, out_i, e.i, out_q, e.q, lat);
            end
         end
      end
   end

   int vcnt;
   int wait_n;

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_chan  = '0;
      in_data  = '0;
      cfg_we   = 1'b0;
      cfg_zero = 1'b0;
      cfg_chan = '0;
      cfg_pinc = '0;
      for (int c = 0; c < NCH; c++) begin
         quad[c] = 0;
         step[c] = 0;
      end
      idle(3);
      rst = 1'b0;
      chk("reset_valid", int'(out_valid), 0);
      chk("reset_i", int'(out_i), 0);
      chk("reset_q", int'(out_q), 0);
      chk("reset_chan", int'(out_chan), 0);

      for (int n = 0; n < 4; n++) cyc1(1, 0, 1000, 0, 0, 0, 0);
      idle(8);

      cyc1(0, 0, 0, 1, 0, 0, 32'h4000_0000);
      for (int n = 0; n < 8; n++) cyc1(1, 0, 1000, 0, 0, 0, 0);
      idle(2);

      cyc1(0, 0, 0, 0, 1, 0, 0);
      cyc1(1, 0, -8192, 0, 0, 0, 0);
      for (int n = 0; n < 3; n++) cyc1(1, 0, -1000, 0, 0, 0, 0);
      idle(2);

      for (int c = 0; c < NCH; c++)
         cyc1(0, 0, 0, 1, 1, c, 32'(c) << 30);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < NCH; c++)
            if (r == 1 && c == 2)
               cyc1(1, 2, 1000, 1, 0, 2, 32'h4000_0000);
            else
               cyc1(1, c, ((r + c) % 2) ? 1000 : -1000, 0, 0, 0, 0);

      cyc1(1, 1, 1000, 0, 0, 0, 0);
      cyc1(1, 1, 1000, 0, 1, 1, 0);
      cyc1(1, 1, 1000, 0, 0, 0, 0);
      cyc1(1, 1, 1000, 0, 0, 0, 0);
      idle(10);
      chk("drain_mid", sb.size(), 0);

      cyc1(1, 0, 1000, 0, 0, 0, 0);
      cyc1(1, 1, 1000, 0, 0, 0, 0);
      cyc1(1, 3, -1000, 0, 0, 0, 0);
      rst = 1'b1;
      sb.delete();
      for (int c = 0; c < NCH; c++) begin
         quad[c] = 0;
         step[c] = 0;
      end
      vcnt = 0;
      for (int n = 0; n < 10; n++) begin
         if (n == 2) rst = 1'b0;
         @(posedge clk);
         #1;
         if (out_valid) vcnt++;
      end
      chk("no_stale_valid", vcnt, 0);
      chk("post_rst_i", int'(out_i), 0);
      chk("post_rst_q", int'(out_q), 0);
      chk("post_rst_chan", int'(out_chan), 0);

      cyc1(1, 1, 1000, 0, 0, 0, 0);
      cyc1(1, 1, 1000, 0, 0, 0, 0);
      cyc1(1, 3, -8192, 0, 0, 0, 0);

      wait_n = 0;
      while (sb.size() != 0 && wait_n < 40) begin
         idle(1);
         wait_n++;
      end
      idle(2);
      chk("drain_end", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
